bash_hash_msg_driver: RTL and testbench
=======================================

Name: bash_hash_msg_driver

Overview:
- Host-side initiator for the bash-hash core control unit. Drives its prep/start request interface.
- Accepts a byte-counted 64-bit message word stream and packs it into rate blocks of (1536-4L) bits.
- Applies bash padding: byte 0x40 after the last message byte, then zeros. Adds an extra pad-only block when required.
- Issues one prep per message, one start per block, holds each block stable while the core absorbs it, and flags completion of the final block.

Parameters:
- L, 256, security level (128/192/256). BLOCK_WORDS = (1536-4L)/64 = 16/12/8.
- WORD_W, 64, message word width. Fixed; other values illegal.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- msg_data_i  in  64  message word; first byte in [63:56]
- msg_bytes_i  in  4  valid bytes in word. Only meaningful with msg_last_i: 0..8. Non-last words are always 8.
- msg_last_i  in  1  final word of message
- msg_valid_i  in  1  word valid
- msg_ready_o  out  1  word accepted when valid&ready
- core_rdy_i  in  1  core control unit ready
- core_active_i  in  1  core control unit absorbing a block
- prep_active_o  out  1  one-cycle request: initialise state for new message
- start_active_o  out  1  one-cycle request: absorb blk_o
- blk_o  out  BLOCK_WORDS*64  current block; word 0 in MSBs
- blk_last_o  out  1  blk_o is the final (padded) block
- done_o  out  1  one-cycle pulse: final block absorbed
- busy_o  out  1  message in progress (state != IDLE)

Behaviour:
- All outputs registered. Reset (async) forces:
  - state IDLE, buffer zero, word index 0, pad_pending 0.
  - Every output 0, including msg_ready_o.
- Reset mid-message discards the partial message; no done_o is produced.
- States: IDLE, PREP, FILL, ISSUE, BUSY, DONE.
- IDLE: when msg_valid_i=1 and core_active_i=0, go to PREP and set prep_active_o=1 for exactly one cycle.
- PREP: one cycle, then FILL with buffer cleared and widx=0.
- FILL: msg_ready_o=1. On each accepted word:
  - Non-last word: store at widx, widx+1. If widx becomes BLOCK_WORDS, go to ISSUE (non-final).
  - Last word, bytes n<8: store bytes 0..n-1, byte n=0x40, rest of block zero, final. Go to ISSUE. n=0 yields 0x40 in byte 0 of that word, which covers the empty message.
  - Last word, n=8, widx<BLOCK_WORDS-1: store the word, put 0x40 in byte 0 of word widx+1, final. Go to ISSUE.
  - Last word, n=8, widx=BLOCK_WORDS-1: block full, non-final. Set pad_pending=1 and go to ISSUE.
- ISSUE: msg_ready_o=0. Wait for core_rdy_i=1 and core_active_i=0, then:
  - start_active_o=1 for one cycle;
  - blk_last_o = final;
  - go to BUSY.
- BUSY: blk_o and blk_last_o held.
  - A seen_active flag must capture core_active_i=1 before completion is accepted. This guards the cycle in which the start request is still in flight.
  - Completion condition: seen_active=1 and core_active_i=0 and core_rdy_i=1.
  - On completion, if final: go to DONE.
  - On completion, if pad_pending: clear buffer, word 0 = 0x4000000000000000, final, clear pad_pending, go to ISSUE. No upstream data is consumed.
  - On completion, otherwise: clear buffer, widx=0, go to FILL.
- DONE: done_o=1 for one cycle, then IDLE. Each message gets a new prep.
- Invariants:
  - prep_active_o never asserted while core_active_i=1.
  - start_active_o never asserted while core_rdy_i=0.
  - Never more than one outstanding start.
  - msg_ready_o is 0 outside FILL.
- msg_bytes_i>8 is illegal (assertion). Behaviour is undefined.

Decomposition:
- bash_hash_pkg holds:
  - driver state enum;
  - WORD_W;
  - PAD_BYTE = 8'h40;
  - function block_words(L);
  - widx width helper.
- Sub-module bash_hash_blk_buf: BLOCK_WORDS x 64 register array with clear, word write, byte-lane mask by count, and pad-byte insertion at (word, byte).

Test Plan:
All scenarios use L=256 (BLOCK_WORDS=8). The bench models the core as: rdy after prep, then core_active_i high for 23 cycles starting the cycle after start_active_o.
1. One word 0xAABBCC0000000000, bytes=3, last -> one prep, one start; blk_o word0=0xAABBCC4000000000, words1-7=0, blk_last_o=1; single done_o after core idle.
2. Eight words of 0x1111111111111111, last with bytes=8 -> two starts. Block 1 all 0x11, blk_last_o=0. Block 2 word0=0x4000000000000000, rest 0, blk_last_o=1. One done_o.
3. Seven full words, last bytes=8 -> one start; word7=0x4000000000000000, blk_last_o=1.
4. Empty message: one word, bytes=0, last -> one prep, one start; word0=0x4000000000000000; done_o.
5. Continuous msg_valid_i, 17-word message -> msg_ready_o=0 throughout ISSUE/BUSY; three starts, each only with core_rdy_i=1; prep never coincident with core_active_i=1; blk_o stable during each BUSY.
6. Assert rst_i during BUSY of block 2 -> all outputs 0 immediately, state IDLE. A following 1-word message completes normally with a fresh prep.

Source files
------------

// File: rtl/bash_hash_pkg.sv
// bash_hash_pkg: shared types, constants and sizing helpers for the bash-hash message driver.
package bash_hash_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_FILL,
        S_ISSUE,
        S_BUSY,
        S_DONE
    } drv_state_e;

    localparam int WORD_W = 64;
    localparam logic [7:0] PAD_BYTE = 8'h40;

    function automatic int block_words(input int l);
        return (1536 - 4 * l) / WORD_W;
    endfunction

    function automatic int widx_w(input int bw);
        return (bw > 1) ? $clog2(bw) : 1;
    endfunction

    // Keeps the first n bytes (MSB first) of a word; n >= 8 keeps all of it.
    function automatic logic [WORD_W-1:0] byte_mask(input logic [3:0] n);
        return (n >= 4'd8) ? '1 : ~({WORD_W{1'b1}} >> {n[2:0], 3'b000});
    endfunction

endpackage

// File: rtl/bash_hash_blk_buf.sv
// bash_hash_blk_buf: rate-block register array with clear, byte-masked word write and pad-byte insert.
module bash_hash_blk_buf
    import bash_hash_pkg::*;
#(
    parameter int BW = 8,
    parameter int IW = widx_w(BW)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 wr_i,
    input  logic [IW-1:0]        wr_idx_i,
    input  logic [WORD_W-1:0]    wr_data_i,
    input  logic [3:0]           wr_bytes_i,
    input  logic                 pad_i,
    input  logic [IW-1:0]        pad_idx_i,
    input  logic [2:0]           pad_byte_i,
    output logic [BW*WORD_W-1:0] blk_o
);

    logic [WORD_W-1:0] buf_q [BW];
    logic [WORD_W-1:0] buf_d [BW];

    // Clear applies first so a new block can be cleared and seeded in one cycle.
    always_comb begin
        for (int i = 0; i < BW; i++) buf_d[i] = clr_i ? '0 : buf_q[i];
        if (wr_i) buf_d[wr_idx_i] = wr_data_i & byte_mask(wr_bytes_i);
        if (pad_i) buf_d[pad_idx_i][8*(7-pad_byte_i) +: 8] = PAD_BYTE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) buf_q <= '{default: '0};
        else buf_q <= buf_d;
    end

    for (genvar g = 0; g < BW; g++) begin : g_out
        assign blk_o[(BW-1-g)*WORD_W +: WORD_W] = buf_q[g];
    end

endmodule

// File: rtl/bash_hash_msg_driver.sv
// bash_hash_msg_driver: packs a byte-counted word stream into padded bash rate blocks
// and drives the core's prep/start handshake, one start per block.
module bash_hash_msg_driver
    import bash_hash_pkg::*;
#(
    parameter int L = 256,
    localparam int BW = block_words(L),
    localparam int IW = widx_w(BW)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [WORD_W-1:0]    msg_data_i,
    input  logic [3:0]           msg_bytes_i,
    input  logic                 msg_last_i,
    input  logic                 msg_valid_i,
    output logic                 msg_ready_o,
    input  logic                 core_rdy_i,
    input  logic                 core_active_i,
    output logic                 prep_active_o,
    output logic                 start_active_o,
    output logic [BW*WORD_W-1:0] blk_o,
    output logic                 blk_last_o,
    output logic                 done_o,
    output logic                 busy_o
);

    drv_state_e    state_q;
    logic [IW-1:0] widx_q;
    logic          final_q, pad_pending_q, seen_active_q;
    logic          ready_q, prep_q, start_q, done_q, last_q, busy_q;

    logic acc, blk_end, short_last, complete;
    logic clr, pad;
    logic [IW-1:0] pad_idx;
    logic [2:0] pad_byte;
    logic [3:0] wr_bytes;

    assign acc        = (state_q == S_FILL) && msg_valid_i && ready_q;
    assign blk_end    = widx_q == IW'(BW - 1);
    assign short_last = msg_bytes_i < 4'd8;
    // seen_active_q masks the cycle where our start is still in flight to the core.
    assign complete   = (state_q == S_BUSY) && seen_active_q && !core_active_i && core_rdy_i;

    assign clr      = (state_q == S_PREP) || (complete && !final_q);
    assign wr_bytes = msg_last_i ? msg_bytes_i : 4'd8;
    assign pad      = (acc && msg_last_i && (short_last || !blk_end)) ||
                      (complete && !final_q && pad_pending_q);
    assign pad_idx  = complete ? '0 : (short_last ? widx_q : widx_q + 1'b1);
    assign pad_byte = complete ? 3'd0 : (short_last ? msg_bytes_i[2:0] : 3'd0);

    bash_hash_blk_buf #(.BW(BW), .IW(IW)) u_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clr_i      (clr),
        .wr_i       (acc),
        .wr_idx_i   (widx_q),
        .wr_data_i  (msg_data_i),
        .wr_bytes_i (wr_bytes),
        .pad_i      (pad),
        .pad_idx_i  (pad_idx),
        .pad_byte_i (pad_byte),
        .blk_o      (blk_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            widx_q        <= '0;
            final_q       <= 1'b0;
            pad_pending_q <= 1'b0;
            seen_active_q <= 1'b0;
            ready_q       <= 1'b0;
            prep_q        <= 1'b0;
            start_q       <= 1'b0;
            done_q        <= 1'b0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            prep_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (msg_valid_i && !core_active_i) begin
                    state_q <= S_PREP;
                    prep_q  <= 1'b1;
                    busy_q  <= 1'b1;
                end
                S_PREP: begin
                    state_q       <= S_FILL;
                    ready_q       <= 1'b1;
                    widx_q        <= '0;
                    final_q       <= 1'b0;
                    pad_pending_q <= 1'b0;
                    last_q        <= 1'b0;
                end
                S_FILL: if (acc) begin
                    widx_q <= widx_q + 1'b1;
                    if (msg_last_i || blk_end) begin
                        state_q       <= S_ISSUE;
                        ready_q       <= 1'b0;
                        final_q       <= msg_last_i && (short_last || !blk_end);
                        pad_pending_q <= msg_last_i && !short_last && blk_end;
                    end
                end
                S_ISSUE: if (core_rdy_i && !core_active_i) begin
                    state_q       <= S_BUSY;
                    start_q       <= 1'b1;
                    last_q        <= final_q;
                    seen_active_q <= 1'b0;
                end
                S_BUSY: begin
                    if (core_active_i) seen_active_q <= 1'b1;
                    if (complete) begin
                        if (final_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (pad_pending_q) begin
                            state_q       <= S_ISSUE;
                            final_q       <= 1'b1;
                            pad_pending_q <= 1'b0;
                        end else begin
                            state_q <= S_FILL;
                            widx_q  <= '0;
                            ready_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign msg_ready_o    = ready_q;
    assign prep_active_o  = prep_q;
    assign start_active_o = start_q;
    assign blk_last_o     = last_q;
    assign done_o         = done_q;
    assign busy_o         = busy_q;

    a_bytes_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        (msg_valid_i && msg_ready_o && msg_last_i) |-> (msg_bytes_i <= 4'd8));

endmodule

// File: tb/tb_bash_hash_msg_driver.sv
// tb_bash_hash_msg_driver: directed tests with a byte-level padding model and a core model.
module tb_bash_hash_msg_driver;

    localparam int BW = 8;
    localparam int BB = BW * 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i = 1'b1;
    logic [63:0]   msg_data_i = '0;
    logic [3:0]    msg_bytes_i = '0;
    logic          msg_last_i = 1'b0, msg_valid_i = 1'b0;
    logic          core_rdy_i = 1'b0, core_active_i = 1'b0;
    logic          msg_ready_o, prep_active_o, start_active_o, blk_last_o, done_o, busy_o;
    logic [BB-1:0] blk_o;

    bash_hash_msg_driver #(.L(256)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .msg_data_i     (msg_data_i),
        .msg_bytes_i    (msg_bytes_i),
        .msg_last_i     (msg_last_i),
        .msg_valid_i    (msg_valid_i),
        .msg_ready_o    (msg_ready_o),
        .core_rdy_i     (core_rdy_i),
        .core_active_i  (core_active_i),
        .prep_active_o  (prep_active_o),
        .start_active_o (start_active_o),
        .blk_o          (blk_o),
        .blk_last_o     (blk_last_o),
        .done_o         (done_o),
        .busy_o         (busy_o)
    );

    typedef struct {
        logic [BB-1:0] blk;
        logic          last;
    } blk_t;

    blk_t exp_q[$];
    blk_t got_q[$];
    int tests = 0, fails = 0;
    int prep_cnt = 0, start_cnt = 0, done_cnt = 0;
    int act_cnt = 0;
    bit rdy_en = 1'b0;
    logic [BB-1:0] cur_blk = '0;
    logic cur_last = 1'b0;

    task automatic check(input string nm, input logic [BB-1:0] act, input logic [BB-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Padding model: message bytes, then 0x40, then zeros to a whole number of 64-byte blocks.
    task automatic model_msg(input logic [63:0] w[$], input int nlast);
        logic [7:0] b[$];
        logic [BB-1:0] blk;
        int nblk;
        for (int i = 0; i < w.size(); i++) begin
            int n = (i == w.size() - 1) ? nlast : 8;
            for (int j = 0; j < n; j++) b.push_back(w[i][63-8*j -: 8]);
        end
        b.push_back(8'h40);
        while (b.size() % 64 != 0) b.push_back(8'h00);
        nblk = b.size() / 64;
        for (int k = 0; k < nblk; k++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk = {blk[BB-9:0], b[k*64+j]};
            exp_q.push_back('{blk: blk, last: (k == nblk - 1)});
        end
    endtask

    // Monitor/compare process plus the core model: core_active for 23 cycles after each start.
    initial forever begin
        @(negedge clk);
        if (!rst_i) begin
            if (prep_active_o) begin
                prep_cnt++;
                check("prep_while_active", core_active_i, 0);
            end
            if (start_active_o) begin
                blk_t e;
                start_cnt++;
                check("start_rdy", core_rdy_i, 1);
                check("start_outstanding", core_active_i, 0);
                check("start_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("blk", blk_o, e.blk);
                    check("blk_last", blk_last_o, e.last);
                end
                cur_blk = blk_o;
                cur_last = blk_last_o;
                got_q.push_back('{blk: blk_o, last: blk_last_o});
            end else if (busy_o && core_active_i) begin
                check("blk_hold", blk_o, cur_blk);
                check("last_hold", blk_last_o, cur_last);
            end
            if (msg_ready_o) check("ready_while_core_busy", core_active_i, 0);
            if (done_o) begin
                done_cnt++;
                check("done_after_final", cur_last, 1);
                check("done_drained", exp_q.size(), 0);
            end
        end
        if (start_active_o) act_cnt = 23;
        else if (act_cnt > 0) act_cnt--;
        if (prep_active_o) rdy_en = 1'b1;
        core_active_i = act_cnt > 0;
        core_rdy_i = rdy_en && act_cnt == 0;
    end

    task automatic send(input logic [63:0] w[$], input int nlast, input bit is_last);
        for (int i = 0; i < w.size(); i++) begin
            int cyc = 0;
            msg_valid_i = 1'b1;
            msg_data_i  = w[i];
            msg_last_i  = is_last && (i == w.size() - 1);
            msg_bytes_i = msg_last_i ? 4'(nlast) : 4'd8;
            while (!msg_ready_o && cyc < 3000) begin
                @(negedge clk);
                cyc++;
            end
            check("ready_wait", msg_ready_o, 1);
            if (!msg_ready_o) break;
            @(negedge clk);
        end
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int cyc = 0;
        while (done_cnt < target && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done_cnt, target);
        repeat (30) @(negedge clk);
        check("done_single", done_cnt, target);
    endtask

    task automatic msg_test(input string nm, input logic [63:0] w[$], input int nlast, input int nstarts);
        int p0 = prep_cnt;
        int s0 = start_cnt;
        int d0 = done_cnt;
        got_q.delete();
        model_msg(w, nlast);
        send(w, nlast, 1'b1);
        wait_done(d0 + 1);
        check({nm, "_preps"}, prep_cnt - p0, 1);
        check({nm, "_starts"}, start_cnt - s0, nstarts);
    endtask

    initial begin
        logic [63:0] w[$];
        blk_t g0, g1, g2;
        int s0, cyc;
        #1;
        check("reset_ctrl", {prep_active_o, start_active_o, done_o, msg_ready_o, busy_o, blk_last_o}, 0);
        check("reset_blk", blk_o, 0);
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        w = {64'hAABBCC0000000000};
        msg_test("t1", w, 3, 1);
        g0 = got_q[0];
        check("t1_word0", g0.blk[BB-1 -: 64], 64'hAABBCC4000000000);
        check("t1_rest", g0.blk[BB-65:0], 0);
        check("t1_last", g0.last, 1);

        w.delete();
        for (int i = 0; i < 8; i++) w.push_back(64'h1111111111111111);
        msg_test("t2", w, 8, 2);
        g0 = got_q[0];
        g1 = got_q[1];
        check("t2_blk1", g0.blk, {8{64'h1111111111111111}});
        check("t2_blk1_last", g0.last, 0);
        check("t2_blk2", g1.blk, {64'h4000000000000000, 448'h0});
        check("t2_blk2_last", g1.last, 1);

        w.delete();
        for (int i = 0; i < 7; i++) w.push_back({8{8'(i + 1)}});
        msg_test("t3", w, 8, 1);
        g0 = got_q[0];
        check("t3_word6", g0.blk[127:64], 64'h0707070707070707);
        check("t3_word7", g0.blk[63:0], 64'h4000000000000000);
        check("t3_last", g0.last, 1);

        w = {64'hFFFFFFFFFFFFFFFF};
        msg_test("t4", w, 0, 1);
        g0 = got_q[0];
        check("t4_blk", g0.blk, {64'h4000000000000000, 448'h0});
        check("t4_last", g0.last, 1);

        w.delete();
        for (int i = 0; i < 17; i++) w.push_back(64'h0102030405060708 + 64'(i));
        msg_test("t5", w, 8, 3);
        g1 = got_q[1];
        g2 = got_q[2];
        check("t5_blk2_last", g1.last, 0);
        check("t5_blk3_word0", g2.blk[BB-1 -: 64], 64'h0102030405060718);
        check("t5_blk3_word1", g2.blk[BB-65 -: 64], 64'h4000000000000000);
        check("t5_blk3_last", g2.last, 1);

        w.delete();
        for (int i = 0; i < 16; i++) w.push_back(64'hA5A5A5A500000000 + 64'(i));
        s0 = start_cnt;
        model_msg(w, 8);
        void'(exp_q.pop_back());
        send(w, 8, 1'b0);
        cyc = 0;
        while (start_cnt < s0 + 2 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_two_starts", start_cnt - s0, 2);
        repeat (5) @(negedge clk);
        rst_i = 1'b1;
        #1;
        check("t6_rst_ctrl", {prep_active_o, start_active_o, done_o, msg_ready_o, busy_o, blk_last_o}, 0);
        check("t6_rst_blk", blk_o, 0);
        check("t6_exp_drained", exp_q.size(), 0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        w = {64'hDEADBEEF00000000};
        msg_test("t6", w, 4, 1);
        g0 = got_q[0];
        check("t6_word0", g0.blk[BB-1 -: 64], 64'hDEADBEEF40000000);
        check("t6_last", g0.last, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
